// File: rtl/cnn16_mem_responder_if.sv
// Bus bundle between the CNN16 datapath/host side (master) and the memory responder (slave).
interface cnn16_mem_responder_if;
   logic        req;
   logic        we;
   logic [11:0] address;
   logic [15:0] to_memory;
   logic        init_we;
   logic [11:0] init_addr;
   logic [15:0] init_data;
   logic [15:0] from_memory;
   logic        ready;
   logic        busy;

   modport master (
      output req, we, address, to_memory, init_we, init_addr, init_data,
      input  from_memory, ready, busy
   );

   modport slave (
      input  req, we, address, to_memory, init_we, init_addr, init_data,
      output from_memory, ready, busy
   );
endinterface

// File: rtl/cnn16_mem_responder.sv
// 4096x16 word memory behind a req/ready handshake with a programmable number of wait states
// and a host preload port that only acts while the responder is idle.
module cnn16_mem_responder #(
   parameter int WAIT_STATES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   cnn16_mem_responder_if.slave  io_bus
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;
   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   logic [15:0] r_mem [0:4095];
   logic [1:0]  r_state;
   logic [3:0]  r_wait_cnt;
   logic        r_ready;
   logic        r_busy;
   logic [15:0] r_rdata;
   logic        r_we;
   logic [11:0] r_addr;
   logic [15:0] r_wdata;

   logic [1:0]  w_state_nxt;
   logic        w_accept;
   logic        w_preload;
   logic        w_enter_resp;
   logic        w_op_we;
   logic [11:0] w_op_addr;
   logic [15:0] w_op_wdata;

   // Next-state decode; preload beats a simultaneous request, nothing is accepted during reset
   always_comb begin
      w_preload    = !rst && (r_state == ST_IDLE) && io_bus.init_we;
      w_accept     = !rst && (r_state == ST_IDLE) && io_bus.req && !io_bus.init_we;
      w_state_nxt  = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (r_wait_cnt == 4'd0) begin
               w_state_nxt = ST_RESP;
            end else begin
               w_state_nxt = ST_WAIT;
            end
         end
         ST_RESP: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
      w_enter_resp = (w_state_nxt == ST_RESP) && (r_state != ST_RESP);
      // With zero wait states the access completes on the accepting edge, before the latch holds it
      if (r_state == ST_IDLE) begin
         w_op_we    = io_bus.we;
         w_op_addr  = io_bus.address;
         w_op_wdata = io_bus.to_memory;
      end else begin
         w_op_we    = r_we;
         w_op_addr  = r_addr;
         w_op_wdata = r_wdata;
      end
   end

   // Control state, request latch, wait counter and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_wait_cnt <= 4'd0;
         r_ready    <= 1'b0;
         r_busy     <= 1'b0;
         r_rdata    <= 16'h0000;
         r_we       <= 1'b0;
         r_addr     <= 12'h000;
         r_wdata    <= 16'h0000;
      end else begin
         r_state <= w_state_nxt;
         r_ready <= (w_state_nxt == ST_RESP);
         r_busy  <= (w_state_nxt != ST_IDLE);
         if (w_accept) begin
            r_we       <= io_bus.we;
            r_addr     <= io_bus.address;
            r_wdata    <= io_bus.to_memory;
            r_wait_cnt <= WAIT_LOAD;
         end else if ((r_state == ST_WAIT) && (r_wait_cnt != 4'd0)) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
         end else begin
            r_wait_cnt <= r_wait_cnt;
         end
         if (w_enter_resp && !w_op_we) begin
            r_rdata <= r_mem[w_op_addr];
         end else begin
            r_rdata <= r_rdata;
         end
      end
   end

   // Storage array; deliberately not reset so preloaded contents survive an aborted access
   always_ff @(posedge clk) begin
      if (w_preload) begin
         r_mem[io_bus.init_addr] <= io_bus.init_data;
      end else if (w_enter_resp && w_op_we) begin
         r_mem[w_op_addr] <= w_op_wdata;
      end
   end

   assign io_bus.from_memory = r_rdata;
   assign io_bus.ready       = r_ready;
   assign io_bus.busy        = r_busy;
endmodule

// File: tb/tb_cnn16_mem_responder.sv
// Directed bench for cnn16_mem_responder: one instance with 2 wait states, one with none.
module tb_cnn16_mem_responder;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   cnn16_mem_responder_if bus2 ();
   cnn16_mem_responder_if bus0 ();

   cnn16_mem_responder u_dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus2)
   );

   cnn16_mem_responder #(.WAIT_STATES(0)) u_dut0 (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload2(input logic [11:0] addr, input logic [15:0] data);
      bus2.init_we   = 1'b1;
      bus2.init_addr = addr;
      bus2.init_data = data;
      tick();
      bus2.init_we   = 1'b0;
   endtask

   // Holds req until ready; lat counts edges from the accepting edge inclusive
   task automatic do_access(input logic wr, input logic [11:0] addr, input logic [15:0] data,
                            output int lat, output int busy_cyc);
      bit done;
      lat = 0;
      busy_cyc = 0;
      done = 1'b0;
      bus2.req       = 1'b1;
      bus2.we        = wr;
      bus2.address   = addr;
      bus2.to_memory = data;
      while (!done && lat < 20) begin
         tick();
         lat++;
         if (bus2.busy) busy_cyc++;
         if (bus2.ready) done = 1'b1;
      end
      bus2.req = 1'b0;
      bus2.we  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got 0 expected 1");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      int bcyc;
      int n_rdy;
      int t1;
      int t2;
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      bus2.req = 1'b0; bus2.we = 1'b0; bus2.address = 12'h000; bus2.to_memory = 16'h0000;
      bus2.init_we = 1'b0; bus2.init_addr = 12'h000; bus2.init_data = 16'h0000;
      bus0.req = 1'b0; bus0.we = 1'b0; bus0.address = 12'h000; bus0.to_memory = 16'h0000;
      bus0.init_we = 1'b0; bus0.init_addr = 12'h000; bus0.init_data = 16'h0000;
      #2;
      check_val("rst_ready", 32'(bus2.ready), 32'd0);
      check_val("rst_busy", 32'(bus2.busy), 32'd0);
      check_val("rst_rdata", 32'(bus2.from_memory), 32'h0000);
      @(negedge clk);
      rst = 1'b0;

      // Preload then read with two wait states
      preload2(12'h010, 16'hBEEF);
      do_access(1'b0, 12'h010, 16'h0000, lat, bcyc);
      check_val("rd010_lat", 32'(lat), 32'd3);
      check_val("rd010_busy_cycles", 32'(bcyc), 32'd3);
      check_val("rd010_data", 32'(bus2.from_memory), 32'hBEEF);
      tick();
      check_val("after_resp_ready", 32'(bus2.ready), 32'd0);
      check_val("after_resp_busy", 32'(bus2.busy), 32'd0);

      // Write does not disturb the read register; read-back returns written word
      do_access(1'b1, 12'hFFF, 16'h1234, lat, bcyc);
      check_val("wrFFF_lat", 32'(lat), 32'd3);
      check_val("wrFFF_rdata_hold", 32'(bus2.from_memory), 32'hBEEF);
      tick();
      do_access(1'b0, 12'hFFF, 16'h0000, lat, bcyc);
      check_val("rdFFF_data", 32'(bus2.from_memory), 32'h1234);
      tick();

      // Back-to-back reads with req held high
      preload2(12'h000, 16'h1111);
      preload2(12'h001, 16'h2222);
      bus2.req = 1'b1; bus2.we = 1'b0; bus2.address = 12'h000;
      n_rdy = 0; t1 = 0; t2 = 0;
      for (int t = 1; t <= 9; t++) begin
         tick();
         if (bus2.ready) begin
            n_rdy++;
            if (n_rdy == 1) begin
               t1 = t;
               check_val("hold_rd0_data", 32'(bus2.from_memory), 32'h1111);
               bus2.address = 12'h001;
            end else begin
               t2 = t;
               check_val("hold_rd1_data", 32'(bus2.from_memory), 32'h2222);
               bus2.req = 1'b0;
            end
         end
      end
      bus2.req = 1'b0;
      check_val("hold_ready_count", 32'(n_rdy), 32'd2);
      check_val("hold_first_lat", 32'(t1), 32'd3);
      check_val("hold_spacing", 32'(t2 - t1), 32'd4);

      // Preload and request in the same idle cycle
      bus2.req = 1'b1; bus2.we = 1'b0; bus2.address = 12'h020;
      bus2.init_we = 1'b1; bus2.init_addr = 12'h020; bus2.init_data = 16'h5555;
      tick();
      check_val("pre_win_busy", 32'(bus2.busy), 32'd0);
      bus2.init_we = 1'b0;
      do_access(1'b0, 12'h020, 16'h0000, lat, bcyc);
      check_val("pre_win_lat", 32'(lat), 32'd3);
      check_val("pre_win_data", 32'(bus2.from_memory), 32'h5555);
      tick();

      // Preload strobe while busy is ignored
      preload2(12'h040, 16'h1357);
      bus2.req = 1'b1; bus2.we = 1'b0; bus2.address = 12'h010;
      tick();
      bus2.init_we = 1'b1; bus2.init_addr = 12'h040; bus2.init_data = 16'h9999;
      tick();
      tick();
      check_val("busy_preload_ready", 32'(bus2.ready), 32'd1);
      bus2.init_we = 1'b0; bus2.req = 1'b0;
      tick();
      do_access(1'b0, 12'h040, 16'h0000, lat, bcyc);
      check_val("busy_preload_ignored", 32'(bus2.from_memory), 32'h1357);
      tick();

      // Reset during WAIT aborts a write
      preload2(12'h030, 16'h0F0F);
      bus2.req = 1'b1; bus2.we = 1'b1; bus2.address = 12'h030; bus2.to_memory = 16'hAAAA;
      tick();
      check_val("abort_in_wait_busy", 32'(bus2.busy), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check_val("abort_async_busy", 32'(bus2.busy), 32'd0);
      check_val("abort_async_ready", 32'(bus2.ready), 32'd0);
      check_val("abort_async_rdata", 32'(bus2.from_memory), 32'h0000);
      bus2.req = 1'b0; bus2.we = 1'b0;
      n_rdy = 0;
      for (int t = 0; t < 3; t++) begin
         tick();
         if (bus2.ready) n_rdy++;
      end
      @(negedge clk);
      rst = 1'b0;
      for (int t = 0; t < 3; t++) begin
         tick();
         if (bus2.ready) n_rdy++;
      end
      check_val("abort_no_ready", 32'(n_rdy), 32'd0);
      do_access(1'b0, 12'h030, 16'h0000, lat, bcyc);
      check_val("abort_rd_lat", 32'(lat), 32'd3);
      check_val("abort_mem_kept", 32'(bus2.from_memory), 32'h0F0F);

      // Zero wait states: ready on the accepting edge, latched address used
      bus0.init_we = 1'b1; bus0.init_addr = 12'h050; bus0.init_data = 16'h0A0A;
      tick();
      bus0.init_addr = 12'h051; bus0.init_data = 16'h0B0B;
      tick();
      bus0.init_we = 1'b0;
      bus0.req = 1'b1; bus0.we = 1'b0; bus0.address = 12'h050;
      tick();
      check_val("ws0_ready", 32'(bus0.ready), 32'd1);
      check_val("ws0_busy", 32'(bus0.busy), 32'd1);
      check_val("ws0_data", 32'(bus0.from_memory), 32'h0A0A);
      bus0.address = 12'h051;
      bus0.req = 1'b0;
      tick();
      check_val("ws0_ready_drop", 32'(bus0.ready), 32'd0);
      check_val("ws0_data_latched", 32'(bus0.from_memory), 32'h0A0A);
      bus0.req = 1'b1;
      tick();
      bus0.req = 1'b0;
      check_val("ws0_rd051_data", 32'(bus0.from_memory), 32'h0B0B);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/cnn16_mem_responder.md
CNN16_MEM_RESPONDER -- requirements
Module: cnn16_mem_responder

Interface
REQ-001 Parameter WAIT_STATES, default 2, number of wait cycles inserted between request acceptance and response (legal range 0..15).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req  input  1  access request from the CNN16 datapath; level, held until ready.
REQ-005 we  input  1  1 = write, 0 = read; sampled with req.
REQ-006 address  input  12  word address from datapath AR.
REQ-007 to_memory  input  16  write data from datapath bus.
REQ-008 init_we  input  1  host preload strobe, one word per cycle.
REQ-009 init_addr  input  12  host preload address.
REQ-010 init_data  input  16  host preload data.
REQ-011 from_memory  output  16  read data to datapath bus source 4.
REQ-012 ready  output  1  one-cycle completion pulse for the accepted access.
REQ-013 busy  output  1  high while an access is in progress (state not IDLE).

Function
REQ-014 Storage SHALL be 4096 x 16-bit words, indexed directly by the 12-bit address; no out-of-range case exists.
REQ-015 FSM states SHALL be IDLE, WAIT, RESP; busy = (state != IDLE).
REQ-016 In IDLE, on an edge with req=1 and init_we=0, the block SHALL latch address, to_memory and we, then go to WAIT if WAIT_STATES>0, else to RESP.
REQ-017 On entry to WAIT, a 4-bit wait counter SHALL load WAIT_STATES-1; it decrements each cycle in WAIT; at 0 the FSM goes to RESP.
REQ-018 On the edge entering RESP, a latched write SHALL update memory, and a latched read SHALL load from_memory with the addressed word.
REQ-019 ready SHALL be high for exactly the one cycle the FSM is in RESP; RESP always returns to IDLE on the next edge.
REQ-020 Latency: ready SHALL rise WAIT_STATES+1 edges after the accepting edge (WAIT_STATES=2 gives 3).
REQ-021 from_memory SHALL hold its last read value until the next read completes; writes SHALL NOT change it.
REQ-022 req SHALL be ignored outside IDLE; the edge after RESP is IDLE, so a held req is accepted again there, which gives a minimum request spacing of WAIT_STATES+2 cycles.
REQ-023 Latched address, data and we SHALL be used for the whole access; input changes after acceptance have no effect.
REQ-024 init_we=1 SHALL write init_data to init_addr only in IDLE; init_we in WAIT or RESP SHALL be ignored.
REQ-025 init_we=1 and req=1 together in IDLE: the preload SHALL win and req SHALL NOT be accepted that cycle; it is accepted on the next IDLE edge with init_we=0.
REQ-026 A read that follows a completed write to the same address SHALL return the written data.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, wait counter 0, ready 0, busy 0, from_memory 16'h0000 and latched request fields 0, with no clock edge required.
REQ-028 Memory contents SHALL NOT be cleared by reset; contents before any write or preload are undefined.
REQ-029 Reset asserted in WAIT or RESP SHALL abort the access: no memory update from a write not yet in RESP, and no ready pulse.
REQ-030 After rst deasserts, the first rising edge with req=1 SHALL be accepted as in REQ-016.

Verification
REQ-031 Preload init_addr=12'h010, init_data=16'hBEEF, then read 12'h010 with WAIT_STATES=2 -> ready high exactly 3 edges after acceptance, from_memory=16'hBEEF, busy high for 3 cycles.
REQ-032 Write 16'h1234 to 12'hFFF, then read 12'hFFF -> second ready with from_memory=16'h1234; from_memory unchanged by the write's ready.
REQ-033 Hold req=1 continuously for reads of 12'h000, then 12'h001 -> exactly one ready per access, spaced 4 cycles apart (WAIT_STATES=2).
REQ-034 Assert req=1 and init_we=1 (addr 12'h020, data 16'h5555) in the same IDLE cycle -> preload completes and req is accepted one cycle later; a read of 12'h020 returns 16'h5555.
REQ-035 Start a write of 16'hAAAA to 12'h030 (which holds 16'h0F0F) and pulse rst during WAIT -> no ready pulse, outputs cleared asynchronously, and a later read of 12'h030 returns 16'h0F0F.
REQ-036 With WAIT_STATES=0: a read is accepted -> ready on the next edge; change address after acceptance -> data still comes from the latched address.
